// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write-to-read bypass and write-port priority.
// It flags write collisions and runs a counter-driven clear sweep after reset or on request.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned WR_PORTS = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RD_PORTS-1:0]          rd_en,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  input  logic [WR_PORTS-1:0]          wr_en,
  input  logic [WR_PORTS*ADDR_W-1:0]   wr_addr,
  input  logic [WR_PORTS*DATA_W-1:0]   wr_data,
  input  logic                         clr_req,
  output logic                         ready,
  output logic                         wr_conflict
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic                ready_q, ready_d;
  logic                wr_conflict_q, wr_conflict_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [WR_PORTS-1:0] wr_ok;
  logic                collision;

  // A port commits only in READY and only to a writable address.
  always_comb begin
    wr_ok = '0;
    for (int unsigned j = 0; j < WR_PORTS; j++) begin
      wr_ok[j] = !rst && (state_q == READY) && wr_en[j] &&
                 ((ZERO_REG == 0) || (wr_addr[j*ADDR_W +: ADDR_W] != '0));
    end
  end

  always_comb begin
    collision = 1'b0;
    for (int unsigned j = 0; j < WR_PORTS; j++) begin
      for (int unsigned k = j + 1; k < WR_PORTS; k++) begin
        if (wr_ok[j] && wr_ok[k] &&
            (wr_addr[j*ADDR_W +: ADDR_W] == wr_addr[k*ADDR_W +: ADDR_W])) begin
          collision = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    clr_ptr_d     = clr_ptr_q;
    ready_d       = ready_q;
    wr_conflict_d = collision;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) begin
          state_d = READY;
          ready_d = 1'b1;
        end
      end
      READY: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
          ready_d   = 1'b0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
        ready_d   = 1'b0;
      end
    endcase
  end

  // Later ports are assigned last, so the highest-index port wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CLEAR;
      clr_ptr_q     <= '0;
      ready_q       <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      ready_q       <= ready_d;
      wr_conflict_q <= wr_conflict_d;
      if (state_q == CLEAR) begin
        mem_q[clr_ptr_q] <= '0;
      end else begin
        for (int unsigned j = 0; j < WR_PORTS; j++) begin
          if (wr_ok[j]) begin
            mem_q[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_word;

    assign ra = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd_word = '0;
      if (!rst && (state_q == READY) && rd_en[i] &&
          !((ZERO_REG != 0) && (ra == '0))) begin
        rd_word = mem_q[ra];
        for (int unsigned j = 0; j < WR_PORTS; j++) begin
          if (wr_ok[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ra)) begin
            rd_word = wr_data[j*DATA_W +: DATA_W];
          end
        end
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = rd_word;
  end

  assign ready       = ready_q;
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp at default parameters.
// Expectations are queued while a cycle is set up and are checked at the following falling edge.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        clr_req;
  logic        ready;
  logic        wr_conflict;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];

  regfile_mp #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .RD_PORTS(2),
    .WR_PORTS(2),
    .ZERO_REG(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .clr_req    (clr_req),
    .ready      (ready),
    .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // sel: 0 = rd_data port0, 1 = rd_data port1, 2 = ready, 3 = wr_conflict
  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t        e;
    logic [31:0] got;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sel)
        0:       got = rd_data[31:0];
        1:       got = rd_data[63:32];
        2:       got = {31'b0, ready};
        default: got = {31'b0, wr_conflict};
      endcase
      check_eq(e.tag, got, e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic en, input logic [4:0] a);
    rd_en[p]         = en;
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
    wr_en[p]           = en;
    wr_addr[p*5 +: 5]   = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic sweep_wait(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      set_wr(0, 1'b1, 5'd5, 32'hDEAD0000 + 32'(k));
      set_wr(1, 1'b1, 5'd7, 32'hBEEF0000 + 32'(k));
      set_rd(0, 1'b1, 5'd5);
      expect_val({tag, "_ready_low"}, 2, 32'd0);
      expect_val({tag, "_rd_zero"}, 0, 32'd0);
      tick();
    end
    wr_en = '0;
  endtask

  initial begin
    rst = 1'b1; clr_req = 1'b0;
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;

    // Reset: outputs are forced to zero even with reads enabled.
    for (int k = 0; k < 3; k++) begin
      set_rd(0, 1'b1, 5'd3);
      expect_val("rst_ready", 2, 32'd0);
      expect_val("rst_conflict", 3, 32'd0);
      expect_val("rst_rd0", 0, 32'd0);
      tick();
    end
    rst = 1'b0;

    // Sweep after reset: ready stays low for 32 edges.
    sweep_wait("sweep0", 32);
    expect_val("sweep0_ready_high", 2, 32'd1);
    tick();

    for (int a = 0; a < 32; a++) begin
      set_rd(0, 1'b1, 5'(a));
      set_rd(1, 1'b1, 5'(31 - a));
      expect_val("cleared_rd0", 0, 32'd0);
      expect_val("cleared_rd1", 1, 32'd0);
      tick();
    end

    // Bypass then storage.
    set_wr(0, 1'b1, 5'd10, 32'hFFFF0000);
    set_rd(0, 1'b1, 5'd10);
    set_rd(1, 1'b1, 5'd10);
    expect_val("bypass_rd0", 0, 32'hFFFF0000);
    expect_val("bypass_rd1", 1, 32'hFFFF0000);
    tick();
    wr_en = '0;
    expect_val("stored_rd0", 0, 32'hFFFF0000);
    expect_val("no_conflict", 3, 32'd0);
    tick();

    // Zero register, including a dual-port write to it.
    set_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    set_wr(1, 1'b1, 5'd0, 32'hFFFFFFFF);
    set_rd(0, 1'b1, 5'd0);
    expect_val("zero_bypass", 0, 32'd0);
    tick();
    wr_en = '0;
    expect_val("zero_stored", 0, 32'd0);
    expect_val("zero_no_conflict", 3, 32'd0);
    tick();

    // Collision: port1 wins, conflict flag for exactly one cycle.
    set_wr(0, 1'b1, 5'd8, 32'h11111111);
    set_wr(1, 1'b1, 5'd8, 32'h22222222);
    set_rd(0, 1'b1, 5'd8);
    expect_val("coll_bypass", 0, 32'h22222222);
    expect_val("coll_flag_before", 3, 32'd0);
    tick();
    wr_en = '0;
    set_rd(1, 1'b0, 5'd8);
    expect_val("coll_flag", 3, 32'd1);
    expect_val("coll_stored", 0, 32'h22222222);
    expect_val("rd1_gated", 1, 32'd0);
    tick();
    expect_val("coll_flag_clear", 3, 32'd0);
    tick();

    // Port1-only write to the top entry, seen through both read ports.
    set_wr(1, 1'b1, 5'd31, 32'hCAFEF00D);
    set_rd(0, 1'b1, 5'd31);
    set_rd(1, 1'b1, 5'd31);
    expect_val("top_bypass_rd1", 1, 32'hCAFEF00D);
    tick();
    wr_en = '0;
    expect_val("top_stored_rd0", 0, 32'hCAFEF00D);
    tick();

    // clr_req mid-operation.
    set_wr(0, 1'b1, 5'd5, 32'hA5A5A5A5);
    tick();
    set_wr(0, 1'b1, 5'd6, 32'h00001234);
    clr_req = 1'b1;
    set_rd(0, 1'b1, 5'd5);
    set_rd(1, 1'b1, 5'd6);
    expect_val("pre_clr_rd0", 0, 32'hA5A5A5A5);
    expect_val("pre_clr_bypass", 1, 32'h00001234);
    expect_val("pre_clr_ready", 2, 32'd1);
    tick();
    clr_req = 1'b0;
    sweep_wait("clr_a", 3);
    clr_req = 1'b1;
    sweep_wait("clr_ign", 1);
    clr_req = 1'b0;
    sweep_wait("clr_b", 28);
    expect_val("clr_ready_high", 2, 32'd1);
    tick();
    for (int a = 5; a <= 10; a++) begin
      set_rd(0, 1'b1, 5'(a));
      set_rd(1, 1'b1, 5'(a + 21));
      expect_val("post_clr_rd0", 0, 32'd0);
      expect_val("post_clr_rd1", 1, 32'd0);
      tick();
    end

    // rst mid-sweep restarts the sweep.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    sweep_wait("mid", 12);
    rst = 1'b1;
    sweep_wait("mid_rst", 2);
    rst = 1'b0;
    sweep_wait("restart", 32);
    expect_val("restart_ready_high", 2, 32'd1);
    tick();

    // rd_en gating with real contents.
    set_wr(0, 1'b1, 5'd12, 32'h5A5A5A5A);
    tick();
    wr_en = '0;
    set_rd(0, 1'b1, 5'd12);
    set_rd(1, 1'b0, 5'd12);
    expect_val("gate_rd0", 0, 32'h5A5A5A5A);
    expect_val("gate_rd1", 1, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
